// File: rtl/instr_dec_pkg.sv
// Shared encodings for the MIPS-31 decode stage: opcode/funct values,
// one-hot class bit positions and the buffered entry layout.
package instr_dec_pkg;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes (instr[5:0])
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   // One-hot class bit positions; bit 31 is never set
   localparam int IDX_ADD   = 0;
   localparam int IDX_ADDU  = 1;
   localparam int IDX_SUB   = 2;
   localparam int IDX_SUBU  = 3;
   localparam int IDX_AND   = 4;
   localparam int IDX_OR    = 5;
   localparam int IDX_XOR   = 6;
   localparam int IDX_NOR   = 7;
   localparam int IDX_SLT   = 8;
   localparam int IDX_SLTU  = 9;
   localparam int IDX_SLL   = 10;
   localparam int IDX_SRL   = 11;
   localparam int IDX_SRA   = 12;
   localparam int IDX_SLLV  = 13;
   localparam int IDX_SRLV  = 14;
   localparam int IDX_SRAV  = 15;
   localparam int IDX_JR    = 16;
   localparam int IDX_ADDI  = 17;
   localparam int IDX_ADDIU = 18;
   localparam int IDX_ANDI  = 19;
   localparam int IDX_ORI   = 20;
   localparam int IDX_XORI  = 21;
   localparam int IDX_LW    = 22;
   localparam int IDX_SW    = 23;
   localparam int IDX_BEQ   = 24;
   localparam int IDX_BNE   = 25;
   localparam int IDX_SLTI  = 26;
   localparam int IDX_SLTIU = 27;
   localparam int IDX_LUI   = 28;
   localparam int IDX_J     = 29;
   localparam int IDX_JAL   = 30;

   // One buffered decode result
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] onehot;
      logic        illegal;
      logic [31:0] imm;
   } dec_entry_t;

endpackage

// File: rtl/instr_dec_core.sv
// Purely combinational instruction classifier: one-hot class, illegal
// flag and extended immediate. STRICT rejects non-zero reserved fields.
module instr_dec_core
   import instr_dec_pkg::*;
#(
   parameter int STRICT = 0
) (
   input  logic [31:0] instr,
   output logic [31:0] onehot,
   output logic        illegal,
   output logic [31:0] imm
);

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  shamt;
   logic [31:0] class_raw;
   logic        resv_bad;

   assign op    = instr[31:26];
   assign funct = instr[5:0];
   assign rs    = instr[25:21];
   assign shamt = instr[10:6];

   // Map {op, funct} to a class bit and flag reserved fields that are non-zero
   always_comb begin
      class_raw = '0;
      resv_bad  = 1'b0;
      case (op)
         OP_RTYPE: begin
            resv_bad = (shamt != 5'd0);
            case (funct)
               FN_ADD:  class_raw[IDX_ADD]  = 1'b1;
               FN_ADDU: class_raw[IDX_ADDU] = 1'b1;
               FN_SUB:  class_raw[IDX_SUB]  = 1'b1;
               FN_SUBU: class_raw[IDX_SUBU] = 1'b1;
               FN_AND:  class_raw[IDX_AND]  = 1'b1;
               FN_OR:   class_raw[IDX_OR]   = 1'b1;
               FN_XOR:  class_raw[IDX_XOR]  = 1'b1;
               FN_NOR:  class_raw[IDX_NOR]  = 1'b1;
               FN_SLT:  class_raw[IDX_SLT]  = 1'b1;
               FN_SLTU: class_raw[IDX_SLTU] = 1'b1;
               FN_SLLV: class_raw[IDX_SLLV] = 1'b1;
               FN_SRLV: class_raw[IDX_SRLV] = 1'b1;
               FN_SRAV: class_raw[IDX_SRAV] = 1'b1;
               // Immediate shifts use shamt; rs is the reserved field instead
               FN_SLL: begin
                  class_raw[IDX_SLL] = 1'b1;
                  resv_bad = (rs != 5'd0);
               end
               FN_SRL: begin
                  class_raw[IDX_SRL] = 1'b1;
                  resv_bad = (rs != 5'd0);
               end
               FN_SRA: begin
                  class_raw[IDX_SRA] = 1'b1;
                  resv_bad = (rs != 5'd0);
               end
               // jr only uses rs; rt, rd and shamt must all be zero
               FN_JR: begin
                  class_raw[IDX_JR] = 1'b1;
                  resv_bad = (instr[20:6] != 15'd0);
               end
               default: class_raw = '0;
            endcase
         end
         OP_ADDI:  class_raw[IDX_ADDI]  = 1'b1;
         OP_ADDIU: class_raw[IDX_ADDIU] = 1'b1;
         OP_ANDI:  class_raw[IDX_ANDI]  = 1'b1;
         OP_ORI:   class_raw[IDX_ORI]   = 1'b1;
         OP_XORI:  class_raw[IDX_XORI]  = 1'b1;
         OP_LW:    class_raw[IDX_LW]    = 1'b1;
         OP_SW:    class_raw[IDX_SW]    = 1'b1;
         OP_BEQ:   class_raw[IDX_BEQ]   = 1'b1;
         OP_BNE:   class_raw[IDX_BNE]   = 1'b1;
         OP_SLTI:  class_raw[IDX_SLTI]  = 1'b1;
         OP_SLTIU: class_raw[IDX_SLTIU] = 1'b1;
         OP_LUI:   class_raw[IDX_LUI]   = 1'b1;
         OP_J:     class_raw[IDX_J]     = 1'b1;
         OP_JAL:   class_raw[IDX_JAL]   = 1'b1;
         default:  class_raw = '0;
      endcase
   end

   // Illegal when no class matched, or reserved fields are dirty in strict mode
   always_comb begin
      illegal = (class_raw == '0) || ((STRICT != 0) && resv_bad);
      onehot  = illegal ? '0 : class_raw;
   end

   // Immediate extension follows the final (masked) class, so illegal sign-extends
   always_comb begin
      if (onehot[IDX_ANDI] | onehot[IDX_ORI] | onehot[IDX_XORI])
         imm = {16'h0000, instr[15:0]};
      else if (onehot[IDX_LUI])
         imm = {instr[15:0], 16'h0000};
      else if (onehot[IDX_J] | onehot[IDX_JAL])
         imm = {6'b000000, instr[25:0]};
      else
         imm = {{16{instr[15]}}, instr[15:0]};
   end

endmodule

// File: rtl/instr_dec_pipe.sv
// Registered decode stage: decodes the incoming word, buffers the result in
// a DEPTH-entry FIFO with valid/ready on both sides, counts legal/illegal pushes.
module instr_dec_pipe
   import instr_dec_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 16,
   parameter int STRICT = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_instr,
   input  logic [31:0]              in_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_onehot,
   output logic                     out_illegal,
   output logic [4:0]               out_rs,
   output logic [4:0]               out_rt,
   output logic [4:0]               out_rd,
   output logic [4:0]               out_shamt,
   output logic [31:0]              out_imm,
   output logic [CNT_W-1:0]         cnt_decoded,
   output logic [CNT_W-1:0]         cnt_illegal,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

   dec_entry_t             mem [DEPTH];
   dec_entry_t             new_entry;
   dec_entry_t             head;
   logic [PTR_W-1:0]       wr_ptr_reg;
   logic [PTR_W-1:0]       rd_ptr_reg;
   logic [OCC_W-1:0]       occ_reg;
   logic [OCC_W-1:0]       occ_next;
   logic [CNT_W-1:0]       cnt_dec_reg;
   logic [CNT_W-1:0]       cnt_ill_reg;
   logic [31:0]            dec_onehot;
   logic                   dec_illegal;
   logic [31:0]            dec_imm;
   logic                   push;
   logic                   pop;

   instr_dec_core #(
      .STRICT (STRICT)
   ) u_core (
      .instr   (in_instr),
      .onehot  (dec_onehot),
      .illegal (dec_illegal),
      .imm     (dec_imm)
   );

   // Handshake: ready depends only on registered occupancy; flush drops the push
   always_comb begin
      in_ready  = (occ_reg < DEPTH_OCC);
      out_valid = (occ_reg != '0);
      push      = in_valid & in_ready & ~flush;
      pop       = out_valid & out_ready;
      new_entry = '{instr: in_instr, pc: in_pc, onehot: dec_onehot,
                    illegal: dec_illegal, imm: dec_imm};
   end

   // Occupancy bookkeeping; simultaneous push and pop leave it unchanged
   always_comb begin
      occ_next = occ_reg;
      case ({push, pop})
         2'b10:   occ_next = occ_reg + 1'b1;
         2'b01:   occ_next = occ_reg - 1'b1;
         default: occ_next = occ_reg;
      endcase
   end

   // Entry storage; no reset so it maps onto plain RAM
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= new_entry;
   end

   // Pointers and occupancy; reset and flush both empty the FIFO
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         occ_reg    <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         occ_reg <= occ_next;
      end
   end

   // Saturating statistics, bumped only on accepted pushes
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_dec_reg <= '0;
         cnt_ill_reg <= '0;
      end else if (push) begin
         if (new_entry.illegal) begin
            if (cnt_ill_reg != '1)
               cnt_ill_reg <= cnt_ill_reg + 1'b1;
         end else begin
            if (cnt_dec_reg != '1)
               cnt_dec_reg <= cnt_dec_reg + 1'b1;
         end
      end
   end

   // Present the head entry; forced to zero while empty so nothing stale leaks out
   always_comb begin
      head        = out_valid ? mem[rd_ptr_reg] : '0;
      out_instr   = head.instr;
      out_pc      = head.pc;
      out_onehot  = head.onehot;
      out_illegal = head.illegal;
      out_imm     = head.imm;
      out_rs      = head.instr[25:21];
      out_rt      = head.instr[20:16];
      out_rd      = head.instr[15:11];
      out_shamt   = head.instr[10:6];
      cnt_decoded = cnt_dec_reg;
      cnt_illegal = cnt_ill_reg;
      occupancy   = occ_reg;
   end

endmodule

// File: tb/tb_instr_dec_pipe.sv
// Scoreboard bench for instr_dec_pipe: a strict and a lax instance see the
// same stimulus; hand-computed expectations are queued at each accepted push
// and a negedge monitor checks every popped head entry.
module tb_instr_dec_pipe;

   localparam int DEPTH = 4;
   localparam int CNT_W = 4;
   localparam int OCC_W = $clog2(DEPTH) + 1;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] oh_s;
      logic        ill_s;
      logic [31:0] oh_l;
      logic        ill_l;
      logic [31:0] imm;
   } vec_t;

   typedef struct {
      vec_t        v;
      logic [31:0] pc;
   } sb_t;

   logic             clk;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic [31:0]      in_instr;
   logic [31:0]      in_pc;
   logic             out_ready;

   logic             s_in_ready, s_out_valid, s_out_illegal;
   logic [31:0]      s_out_instr, s_out_pc, s_out_onehot, s_out_imm;
   logic [4:0]       s_out_rs, s_out_rt, s_out_rd, s_out_shamt;
   logic [CNT_W-1:0] s_cnt_dec, s_cnt_ill;
   logic [OCC_W-1:0] s_occ;

   logic             l_in_ready, l_out_valid, l_out_illegal;
   logic [31:0]      l_out_instr, l_out_pc, l_out_onehot, l_out_imm;
   logic [4:0]       l_out_rs, l_out_rt, l_out_rd, l_out_shamt;
   logic [CNT_W-1:0] l_cnt_dec, l_cnt_ill;
   logic [OCC_W-1:0] l_occ;

   int               n_checks = 0;
   int               n_fail   = 0;
   sb_t              sb[$];
   logic [31:0]      pc_next  = 32'h0040_0000;
   int               m_dec_s = 0, m_ill_s = 0, m_dec_l = 0, m_ill_l = 0;

   instr_dec_pipe #(.DEPTH(DEPTH), .CNT_W(CNT_W), .STRICT(1)) dut_s (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .out_instr(s_out_instr), .out_pc(s_out_pc), .out_onehot(s_out_onehot),
      .out_illegal(s_out_illegal), .out_rs(s_out_rs), .out_rt(s_out_rt),
      .out_rd(s_out_rd), .out_shamt(s_out_shamt), .out_imm(s_out_imm),
      .cnt_decoded(s_cnt_dec), .cnt_illegal(s_cnt_ill), .occupancy(s_occ)
   );

   instr_dec_pipe #(.DEPTH(DEPTH), .CNT_W(CNT_W), .STRICT(0)) dut_l (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(l_in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(l_out_valid), .out_ready(out_ready),
      .out_instr(l_out_instr), .out_pc(l_out_pc), .out_onehot(l_out_onehot),
      .out_illegal(l_out_illegal), .out_rs(l_out_rs), .out_rt(l_out_rt),
      .out_rd(l_out_rd), .out_shamt(l_out_shamt), .out_imm(l_out_imm),
      .cnt_decoded(l_cnt_dec), .cnt_illegal(l_cnt_ill), .occupancy(l_occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] oh_s,
                               input logic ill_s, input logic [31:0] oh_l,
                               input logic ill_l, input logic [31:0] imm);
      vec_t v;
      v.instr = instr; v.oh_s = oh_s; v.ill_s = ill_s;
      v.oh_l  = oh_l;  v.ill_l = ill_l; v.imm = imm;
      return v;
   endfunction

   function automatic int sat_inc(input int c);
      return (c >= (1 << CNT_W) - 1) ? c : c + 1;
   endfunction

   // Offer one instruction until accepted; queue its expectation on acceptance
   task automatic send(input vec_t v);
      logic acc;
      int   waits = 0;
      in_valid = 1'b1;
      in_instr = v.instr;
      in_pc    = pc_next;
      do begin
         acc = s_in_ready;
         @(posedge clk);
         #1;
         waits++;
      end while (!acc && waits < 40);
      if (!acc) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: instr %h never accepted, expected accept within 40 cycles", v.instr);
      end else begin
         sb.push_back('{v: v, pc: pc_next});
         pc_next += 32'd4;
         if (v.ill_s) m_ill_s = sat_inc(m_ill_s); else m_dec_s = sat_inc(m_dec_s);
         if (v.ill_l) m_ill_l = sat_inc(m_ill_l); else m_dec_l = sat_inc(m_dec_l);
         $display("push %h pc=%h", v.instr, in_pc);
      end
      in_valid = 1'b0;
   endtask

   task automatic check_counters(input string tag);
      chk({tag, "_cnt_dec_s"}, 32'(s_cnt_dec), 32'(m_dec_s));
      chk({tag, "_cnt_ill_s"}, 32'(s_cnt_ill), 32'(m_ill_s));
      chk({tag, "_cnt_dec_l"}, 32'(l_cnt_dec), 32'(m_dec_l));
      chk({tag, "_cnt_ill_l"}, 32'(l_cnt_ill), 32'(m_ill_l));
   endtask

   task automatic drain(input string tag);
      int n = 0;
      out_ready = 1'b1;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_drain_left"}, 32'(sb.size()), 32'd0);
      chk({tag, "_drain_occ"}, 32'(s_occ), 32'd0);
   endtask

   // Monitor: every cycle the head is consumed, compare against the queue front
   always @(negedge clk) begin
      if (!rst && s_out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_unexpected: got instr %h, expected no entry", s_out_instr);
         end else begin
            sb_t e;
            e = sb.pop_front();
            chk("instr",   s_out_instr, e.v.instr);
            chk("pc",      s_out_pc, e.pc);
            chk("onehot",  s_out_onehot, e.v.oh_s);
            chk("illegal", 32'(s_out_illegal), 32'(e.v.ill_s));
            chk("imm",     s_out_imm, e.v.imm);
            chk("fields",  {12'h0, s_out_rs, s_out_rt, s_out_rd, s_out_shamt},
                           {12'h0, e.v.instr[25:21], e.v.instr[20:16],
                            e.v.instr[15:11], e.v.instr[10:6]});
            chk("lax_valid",   32'(l_out_valid), 32'd1);
            chk("lax_onehot",  l_out_onehot, e.v.oh_l);
            chk("lax_illegal", 32'(l_out_illegal), 32'(e.v.ill_l));
            $display("pop  %h pc=%h onehot=%h ill=%0d imm=%h",
                     s_out_instr, s_out_pc, s_out_onehot, s_out_illegal, s_out_imm);
         end
      end
   end

   vec_t v_add, v_ori, v_lui, v_addi, v_bad, v_sll1, v_and, v_or, v_xor, v_nor, v_sw;
   vec_t v_beq, v_bne, v_j, v_jal, v_jr, v_jr_bad, v_addu_sh, v_fn01, v_sra, v_nop, v_slti;
   vec_t misc[$];

   initial begin
      v_add     = mk(32'h0022_1820, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0, 32'h0000_1820);
      v_ori     = mk(32'h3421_FFFF, 32'h0010_0000, 1'b0, 32'h0010_0000, 1'b0, 32'h0000_FFFF);
      v_lui     = mk(32'h3C01_1234, 32'h1000_0000, 1'b0, 32'h1000_0000, 1'b0, 32'h1234_0000);
      v_addi    = mk(32'h2021_FFFF, 32'h0002_0000, 1'b0, 32'h0002_0000, 1'b0, 32'hFFFF_FFFF);
      v_bad     = mk(32'hFC00_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000);
      v_sll1    = mk(32'h0021_0040, 32'h0000_0000, 1'b1, 32'h0000_0400, 1'b0, 32'h0000_0040);
      v_and     = mk(32'h00A6_2024, 32'h0000_0010, 1'b0, 32'h0000_0010, 1'b0, 32'h0000_2024);
      v_or      = mk(32'h0109_3825, 32'h0000_0020, 1'b0, 32'h0000_0020, 1'b0, 32'h0000_3825);
      v_xor     = mk(32'h016C_5026, 32'h0000_0040, 1'b0, 32'h0000_0040, 1'b0, 32'h0000_5026);
      v_nor     = mk(32'h01CF_6827, 32'h0000_0080, 1'b0, 32'h0000_0080, 1'b0, 32'h0000_6827);
      v_sw      = mk(32'hAFA2_0008, 32'h0080_0000, 1'b0, 32'h0080_0000, 1'b0, 32'h0000_0008);
      v_beq     = mk(32'h1022_FFFF, 32'h0100_0000, 1'b0, 32'h0100_0000, 1'b0, 32'hFFFF_FFFF);
      v_bne     = mk(32'h1423_FFFE, 32'h0200_0000, 1'b0, 32'h0200_0000, 1'b0, 32'hFFFF_FFFE);
      v_j       = mk(32'h0810_0000, 32'h2000_0000, 1'b0, 32'h2000_0000, 1'b0, 32'h0010_0000);
      v_jal     = mk(32'h0FFF_FFFF, 32'h4000_0000, 1'b0, 32'h4000_0000, 1'b0, 32'h03FF_FFFF);
      v_jr      = mk(32'h03E0_0008, 32'h0001_0000, 1'b0, 32'h0001_0000, 1'b0, 32'h0000_0008);
      v_jr_bad  = mk(32'h03E0_0048, 32'h0000_0000, 1'b1, 32'h0001_0000, 1'b0, 32'h0000_0048);
      v_addu_sh = mk(32'h0022_1861, 32'h0000_0000, 1'b1, 32'h0000_0002, 1'b0, 32'h0000_1861);
      v_fn01    = mk(32'h0000_0001, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0001);
      v_sra     = mk(32'h0002_1043, 32'h0000_1000, 1'b0, 32'h0000_1000, 1'b0, 32'h0000_1043);
      v_nop     = mk(32'h0000_0000, 32'h0000_0400, 1'b0, 32'h0000_0400, 1'b0, 32'h0000_0000);
      v_slti    = mk(32'h2800_0005, 32'h0400_0000, 1'b0, 32'h0400_0000, 1'b0, 32'h0000_0005);

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      chk("rst_in_ready", 32'(s_in_ready), 32'd1);
      chk("rst_out_valid", 32'(s_out_valid), 32'd0);
      chk("rst_occ", 32'(s_occ), 32'd0);
      check_counters("rst");

      // Single add, then the immediate forms back-to-back
      out_ready = 1'b1;
      send(v_add);
      chk("add_cnt_dec", 32'(s_cnt_dec), 32'd1);
      send(v_ori);
      send(v_lui);
      send(v_addi);
      drain("imm");
      check_counters("imm");

      // Illegal opcode and strict-only illegal shift
      send(v_bad);
      send(v_sll1);
      drain("illegal");
      chk("illegal_cnt_s", 32'(s_cnt_ill), 32'd2);
      chk("illegal_cnt_l", 32'(l_cnt_ill), 32'd1);
      check_counters("illegal");

      // Remaining classes and reserved-field cases
      misc = '{v_beq, v_bne, v_j, v_jal, v_jr, v_jr_bad, v_addu_sh, v_fn01, v_sra};
      foreach (misc[i]) send(misc[i]);
      drain("misc");
      check_counters("misc");

      // Fill with consumer stalled; the extra instruction must wait
      out_ready = 1'b0;
      send(v_and);
      send(v_or);
      send(v_xor);
      send(v_nor);
      chk("full_in_ready", 32'(s_in_ready), 32'd0);
      chk("full_occ", 32'(s_occ), 32'(DEPTH));
      chk("full_head", s_out_instr, v_and.instr);
      in_valid = 1'b1;
      in_instr = v_sw.instr;
      in_pc    = pc_next;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("stall_occ", 32'(s_occ), 32'(DEPTH));
      chk("stall_head", s_out_instr, v_and.instr);
      chk("stall_head_imm", s_out_imm, v_and.imm);
      out_ready = 1'b1;
      send(v_sw);
      drain("wrap");
      check_counters("wrap");

      // Flush with a push offered in the same cycle; one slot left free so it was acceptable
      out_ready = 1'b0;
      send(v_nop);
      send(v_nop);
      send(v_nop);
      chk("preflush_occ", 32'(s_occ), 32'd3);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_instr = v_slti.instr;
      in_pc    = pc_next;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      chk("flush_occ", 32'(s_occ), 32'd0);
      chk("flush_out_valid", 32'(s_out_valid), 32'd0);
      chk("flush_in_ready", 32'(s_in_ready), 32'd1);
      check_counters("flush");

      // Saturate the legal counter
      out_ready = 1'b1;
      repeat (16) send(v_nop);
      drain("sat");
      chk("sat_cnt_dec_s", 32'(s_cnt_dec), 32'h0000_000F);
      chk("sat_cnt_dec_l", 32'(l_cnt_dec), 32'h0000_000F);
      check_counters("sat");

      // Reset mid-stream drops buffered entries and clears the counters
      out_ready = 1'b0;
      send(v_ori);
      send(v_lui);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      m_dec_s = 0; m_ill_s = 0; m_dec_l = 0; m_ill_l = 0;
      chk("mrst_occ", 32'(s_occ), 32'd0);
      chk("mrst_out_valid", 32'(s_out_valid), 32'd0);
      chk("mrst_in_ready", 32'(s_in_ready), 32'd1);
      chk("mrst_out_instr", s_out_instr, 32'd0);
      chk("mrst_out_imm", s_out_imm, 32'd0);
      check_counters("mrst");

      // Normal operation after reset
      out_ready = 1'b1;
      send(v_add);
      drain("post");
      check_counters("post");

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_dec_pipe.md
Name: instr_dec_pipe

Overview:
- Registered MIPS-31 instruction decode stage between fetch and execute.
- Decodes each accepted 32-bit instruction into a 32-bit one-hot class vector, an explicit illegal flag, extracted register fields and an extended immediate.
- Buffers results in a parametrised FIFO with valid/ready handshakes on both sides, so fetch and execute stalls decouple.
- Keeps saturating counters of decoded and illegal instructions.

Parameters:
DEPTH, 2, FIFO entries; power of two, >=2
CNT_W, 16, width of the statistics counters
STRICT, 0, 1 = reserved fields must be zero for a legal decode (see Behaviour)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  discard all buffered entries this cycle
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept (count < DEPTH)
in_instr  in  32  instruction word
in_pc  in  32  instruction address
out_valid  out  1  head entry valid
out_ready  in  1  execute consumes head entry
out_instr  out  32  head instruction word
out_pc  out  32  head address
out_onehot  out  32  head one-hot class; all zero when illegal
out_illegal  out  1  head instruction illegal
out_rs, out_rt, out_rd, out_shamt  out  5 each  instr[25:21], [20:16], [15:11], [10:6]
out_imm  out  32  extended immediate of the head entry
cnt_decoded  out  CNT_W  legal instructions accepted
cnt_illegal  out  CNT_W  illegal instructions accepted
occupancy  out  $clog2(DEPTH)+1  entries held

Behaviour:
- One-hot bit map, key = {op[31:26], funct[5:0]}:
  - R-type (op 0), funct: 0 add 20h, 1 addu 21h, 2 sub 22h, 3 subu 23h, 4 and 24h, 5 or 25h, 6 xor 26h, 7 nor 27h, 8 slt 2Ah, 9 sltu 2Bh, 10 sll 00h, 11 srl 02h, 12 sra 03h, 13 sllv 04h, 14 srlv 06h, 15 srav 07h, 16 jr 08h.
  - Other opcodes, funct ignored: 17 addi 08h, 18 addiu 09h, 19 andi 0Ch, 20 ori 0Dh, 21 xori 0Eh, 22 lw 23h, 23 sw 2Bh, 24 beq 04h, 25 bne 05h, 26 slti 0Ah, 27 sltiu 0Bh, 28 lui 0Fh, 29 j 02h, 30 jal 03h.
  - Bit 31 is always 0.
- Any other key decodes illegal: onehot=0, illegal=1. Output is never X.
- STRICT=1 additionally makes these illegal:
  - sll/srl/sra with rs != 0.
  - jr with instr[20:6] != 0.
  - Any other R-type with shamt != 0.
- out_imm:
  - andi/ori/xori: zero-extend instr[15:0].
  - lui: {instr[15:0], 16'h0}.
  - j/jal: {6'b0, instr[25:0]}.
  - All other classes, including illegal: sign-extend instr[15:0].
- Decode is combinational on in_instr. The result is written into the FIFO on push (in_valid & in_ready).
- Latency: push at edge N into an empty FIFO gives out_valid=1 with that entry at N+1. There is no combinational in-to-out path.
- Pop = out_valid & out_ready. Push and pop in the same cycle keep occupancy unchanged.
- in_ready = (occupancy < DEPTH), a pure function of registered state. When full, a simultaneous pop does not enable a push that cycle.
- Read/write pointers are $clog2(DEPTH) bits and wrap naturally. Outputs show the head entry. Out fields are don't-care only when out_valid=0 and must hold stable while out_valid & !out_ready.
- Counters: increment on push (cnt_decoded if legal, else cnt_illegal) and saturate at all ones.
- flush:
  - Next cycle occupancy=0 and out_valid=0.
  - Any push in the flush cycle is discarded and not counted.
  - Counters are otherwise unaffected.
- rst, priority over flush: pointers, occupancy, out_valid, cnt_decoded and cnt_illegal go to 0. in_ready reads 1 from the first cycle after reset. Reset mid-stream drops all entries.

Decomposition:
- Package instr_dec_pkg:
  - Opcode/funct localparams, one-hot bit index localparams (IDX_ADD..IDX_JAL).
  - Entry struct {instr, pc, onehot, illegal, imm}.
- Sub-module instr_dec_core: purely combinational. Takes instr and the STRICT parameter; produces onehot, illegal and imm. Fields come from instr slicing in the top level.
- instr_dec_pipe holds the FIFO, handshake and counters.

Test Plan:
- Reset, then push add $3,$1,$2 (00221820h) with out_ready=1 -> next cycle out_valid=1, out_onehot=00000001h, out_illegal=0, rs=1, rt=2, rd=3, cnt_decoded=1.
- Push ori 3421FFFFh, lui 3C011234h, addi 2021FFFFh back-to-back -> out_imm 0000FFFFh, 12340000h, FFFFFFFFh; onehot bits 20, 28, 17.
- Push FC000000h, then STRICT=1 sll with rs=1 (00210040h) -> both out_illegal=1, onehot=0, cnt_illegal=2. With STRICT=0, sll decodes bit 10.
- Hold out_ready=0, push DEPTH+1 instructions -> in_ready=0 after DEPTH pushes, occupancy=DEPTH. Head fields stable. Drain yields FIFO order with pointer wrap.
- Fill FIFO, assert flush together with in_valid=1 -> next cycle occupancy=0, out_valid=0, counters unchanged by the flushed push.
- Force cnt_decoded to all ones (CNT_W=4, 16 pushes) -> stays Fh. Then rst mid-stream -> all outputs 0 next cycle, in_ready=1.
